// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states and the
// prefetch FIFO entry layout.
package ifetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_ctrl_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs; head is read straight from the
// registered storage. Flush empties it and wins over push/pop.
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_din,
    output fetch_entry_t o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_push;
    logic         w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_din;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the imem word address,
// buffers fetched instructions and hands them to decode over valid/ready.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned AWIDTH   = 6,
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       imem_addr,
    input  logic [DWIDTH-1:0] imem_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_instr,
    output logic [31:0]       out_pc,
    output logic [1:0]        state_o,
    output logic              misalign_err
);

    state_t       r_state;
    state_t       w_next_state;
    logic [31:0]  r_pc;
    logic         r_misalign;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    fetch_entry_t w_din;
    fetch_entry_t w_head;

    assign w_pop  = out_valid && out_ready;
    // halt suspends fetching immediately, even in the cycle before HALTED.
    assign w_push = (r_state == RUN) && !halt && !redirect_valid &&
                    (!w_full || w_pop);

    assign w_din.pc    = r_pc;
    assign w_din.instr = imem_instr;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_din   (w_din),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_next_state = r_state;
        if (redirect_valid) begin
            // A redirect keeps the state, except that a concurrent halt parks us.
            if (halt && r_state != IDLE) begin
                w_next_state = HALTED;
            end
        end else begin
            unique case (r_state)
                IDLE:    if (start && !halt) w_next_state = RUN;
                RUN:     if (halt)           w_next_state = HALTED;
                HALTED:  if (!halt)          w_next_state = RUN;
                default:                     w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (redirect_valid) begin
                r_pc <= {redirect_pc[31:2], 2'b00};
                if (redirect_pc[1:0] != 2'b00) begin
                    r_misalign <= 1'b1;
                end
            end else if (w_push) begin
                r_pc <= r_pc + PC_STEP;
            end
        end
    end

    assign imem_addr    = {{(32-AWIDTH){1'b0}}, r_pc[AWIDTH+1:2]};
    assign out_valid    = !w_empty;
    assign out_instr    = w_head.instr;
    assign out_pc       = w_head.pc;
    assign state_o      = r_state;
    assign misalign_err = r_misalign;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: a queue-based reference model predicts
// FIFO contents, PC and state; a negedge monitor compares the DUT against it.
module tb_ifetch_ctrl;

    localparam int unsigned DEPTH = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [1:0]  state_o;
    logic        misalign_err;

    logic [31:0] imem [64];
    int          total = 0;
    int          bad = 0;

    exp_t        q[$];
    logic [31:0] m_pc = '0;
    int          m_st = 0;
    logic        m_mis = 1'b0;

    always #5 clk = ~clk;

    assign imem_instr = imem[imem_addr[5:0]];

    ifetch_ctrl #(.DWIDTH(32), .AWIDTH(6), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .state_o        (state_o),
        .misalign_err   (misalign_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: rules of the fetch unit stated directly on a queue.
    initial begin
        bit pop;
        bit fetch;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                q.delete();
                m_pc  = 32'h0;
                m_st  = 0;
                m_mis = 1'b0;
            end else if (redirect_valid) begin
                q.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
                if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
                if (halt && m_st != 0) m_st = 2;
            end else begin
                pop   = (q.size() > 0) && out_ready;
                fetch = (m_st == 1) && !halt && (q.size() < DEPTH || pop);
                if (pop) void'(q.pop_front());
                if (fetch) begin
                    q.push_back('{m_pc, 32'hA000_0000 + {26'b0, m_pc[7:2]}});
                    m_pc = m_pc + 32'd4;
                end
                if (m_st == 0 && start && !halt) m_st = 1;
                else if (m_st == 1 && halt) m_st = 2;
                else if (m_st == 2 && !halt) m_st = 1;
            end
        end
    end

    // Monitor: compare presented outputs against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
            if (q.size() > 0) begin
                chk("out_pc", out_pc, q[0].pc);
                chk("out_instr", out_instr, q[0].instr);
            end
            chk("imem_addr", imem_addr, {26'b0, m_pc[7:2]});
            chk("state", {30'b0, state_o}, m_st);
            chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
        end
    end

    task automatic cyc(input logic s, input logic h, input logic rv,
                       input logic [31:0] rpc, input logic rdy, input int n);
        for (int k = 0; k < n; k++) begin
            start          = s;
            halt           = h;
            redirect_valid = rv;
            redirect_pc    = rpc;
            out_ready      = rdy;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_instr"}, out_instr, 32'd0);
        chk({tag, "_pc"}, out_pc, 32'd0);
        chk({tag, "_state"}, {30'b0, state_o}, 32'd0);
        chk({tag, "_mis"}, {31'b0, misalign_err}, 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'd0);
    endtask

    initial begin
        for (int n = 0; n < 64; n++) imem[n] = 32'hA000_0000 + n;

        #1 reset = 1'b1;
        #2 chk_reset_outputs("rst0");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        cyc(1, 0, 0, 0, 1, 1);           // start, streaming
        cyc(0, 0, 0, 0, 1, 5);
        cyc(0, 0, 0, 0, 0, 5);           // backpressure: FIFO fills, PC freezes
        cyc(0, 0, 0, 0, 1, 3);
        cyc(0, 0, 0, 0, 0, 3);           // fill, then redirect while full
        cyc(0, 0, 1, 32'h40, 1, 1);
        cyc(0, 0, 0, 0, 1, 4);
        cyc(0, 0, 1, 32'hF8, 1, 1);      // imem index wraps 63 -> 0
        cyc(0, 0, 0, 0, 1, 5);
        cyc(0, 1, 0, 0, 1, 4);           // halt: drain then idle output
        cyc(0, 0, 0, 0, 1, 4);
        cyc(0, 0, 1, 32'h22, 1, 1);      // misaligned target
        cyc(0, 0, 0, 0, 1, 3);
        chk("misalign_sticky", {31'b0, misalign_err}, 32'd1);
        cyc(0, 0, 0, 0, 0, 3);

        #2 reset = 1'b1;                 // asynchronous reset mid-burst
        #1 chk_reset_outputs("rst1");
        @(posedge clk);
        #1 reset = 1'b0;

        cyc(1, 0, 0, 0, 1, 2);
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom % 4) == 0, ($urandom % 8) == 0, ($urandom % 16) == 0,
                $urandom, ($urandom % 4) != 0, 1);
        end
        cyc(1, 0, 1, 32'hFFFF_FFF8, 1, 1);   // 32-bit PC wrap
        cyc(1, 0, 0, 0, 1, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
